// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Optional statistics counters are enabled with FWD_STATS_EN.
package fwd_pkg;

  // Register index width that the scoreboard entry layout is built around.
  localparam int unsigned FWD_REG_AW = 5;

  // A select value of zero means the operand comes from the register file.
  localparam int unsigned SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  is_load;
  } fwd_entry_t;

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority match of one source register against the forwardable stages.
// Returns the producer's stage as seen in the consumer's EX cycle.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 3,
  parameter int unsigned SELW       = 2
) (
  input  logic [REG_AW-1:0]  rs_i,
  // Stages 1..DEPTH-1; stage DEPTH is writing back and never forwards.
  input  fwd_entry_t [DEPTH-2:0] entries_i,
  output logic [SELW-1:0]    sel_o,
  output logic               load_nr_o
);

  always_comb begin
    sel_o     = SELW'(SEL_RF);
    load_nr_o = 1'b0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int j = int'(DEPTH) - 1; j >= 1; j--) begin
      if (entries_i[j-1].valid && (rs_i != '0) &&
          (entries_i[j-1].rd == FWD_REG_AW'(rs_i))) begin
        sel_o     = SELW'(j + 1);
        load_nr_o = entries_i[j-1].is_load && ((j + 1) < int'(LOAD_READY));
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard scoreboard for the in-order integer pipeline.
// Define FWD_STATS_EN to add saturating stall/forward statistics counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 3,
  localparam int unsigned SELW      = sel_width(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   issue_valid_i,
  input  logic                   issue_wen_i,
  input  logic                   issue_load_i,
  input  logic [REG_AW-1:0]      issue_rd_i,
  input  logic [NSRC*REG_AW-1:0] issue_rs_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic [NSRC*SELW-1:0]   fwd_sel_o,
  output logic                   hazard_stall_o
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            fwd_cnt_o
`endif
);

  // Stage DEPTH only retires, so only stages 1..DEPTH-1 need to be held.
  localparam int unsigned NTRACK = DEPTH - 1;

  fwd_entry_t [NTRACK-1:0] entries_q, entries_d;
  fwd_entry_t              new_entry;
  logic [NSRC*SELW-1:0]    sel_comb, fwd_sel_d, fwd_sel_q;
  logic [NSRC-1:0]         load_nr;
  logic                    bubble;

  for (genvar n = 0; n < NSRC; n++) begin : g_src
    fwd_match #(
      .REG_AW     (REG_AW),
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY),
      .SELW       (SELW)
    ) u_match (
      .rs_i      (issue_rs_i[n*REG_AW +: REG_AW]),
      .entries_i (entries_q),
      .sel_o     (sel_comb[n*SELW +: SELW]),
      .load_nr_o (load_nr[n])
    );
  end

  always_comb begin
    hazard_stall_o = issue_valid_i & ~flush_i & (|load_nr);
    bubble         = hazard_stall_o | flush_i | ~issue_valid_i;

    new_entry = '0;
    if (!bubble && issue_wen_i && (issue_rd_i != '0)) begin
      new_entry.valid   = 1'b1;
      new_entry.rd      = FWD_REG_AW'(issue_rd_i);
      new_entry.is_load = issue_load_i;
    end

    entries_d = entries_q;
    fwd_sel_d = fwd_sel_q;
    if (!stall_i) begin
      for (int i = int'(NTRACK) - 1; i >= 1; i--) begin
        entries_d[i] = entries_q[i-1];
      end
      entries_d[0] = new_entry;
      fwd_sel_d    = bubble ? '0 : sel_comb;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      entries_q <= '0;
      fwd_sel_q <= '0;
    end else begin
      entries_q <= entries_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign fwd_sel_o = fwd_sel_q;

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] fwd_cnt_d, fwd_cnt_q;
  logic [31:0] fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc = '0;
    if (!stall_i && !bubble) begin
      for (int n = 0; n < int'(NSRC); n++) begin
        if (sel_comb[n*SELW +: SELW] != '0) fwd_inc = fwd_inc + 32'd1;
      end
    end
    fwd_sum   = {1'b0, fwd_cnt_q} + {1'b0, fwd_inc};
    fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];

    stall_cnt_d = stall_cnt_q;
    if (hazard_stall_o && !stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (default parameters).
// Counter checks are added when FWD_STATS_EN is defined.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid, issue_wen, issue_load, stall, flush;
  logic [4:0]  issue_rd;
  logic [9:0]  issue_rs;
  logic [3:0]  fwd_sel;
  logic        hazard;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  fwd_scoreboard u_dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_wen_i    (issue_wen),
    .issue_load_i   (issue_load),
    .issue_rd_i     (issue_rd),
    .issue_rs_i     (issue_rs),
    .stall_i        (stall),
    .flush_i        (flush),
    .fwd_sel_o      (fwd_sel),
    .hazard_stall_o (hazard)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .fwd_cnt_o      (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sel(input string tag, input int unsigned e0, input int unsigned e1);
    check({tag, "/src0"}, 32'(fwd_sel[1:0]), 32'(e0));
    check({tag, "/src1"}, 32'(fwd_sel[3:2]), 32'(e1));
  endtask

  task automatic issue(input logic v, input logic wen, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    issue_valid = v;
    issue_wen   = wen;
    issue_load  = ld;
    issue_rd    = rd;
    issue_rs    = {rs1, rs0};
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    stall = 1'b0;
    flush = 1'b0;
    issue(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_sel("reset", 0, 0);
    check("reset_haz", 32'(hazard), 0);
    rst_n = 1'b1;

    // Empty board
    issue(1, 0, 0, 0, 3, 4);
    #1 check("empty_haz", 32'(hazard), 0);
    tick(); chk_sel("empty", 0, 0);

    // ALU chain: producer in EX, MEM, then retiring
    issue(1, 1, 0, 5, 0, 0); tick();
    issue(1, 0, 0, 0, 5, 0); tick(); chk_sel("alu_s2", 2, 0);
    issue(1, 0, 0, 0, 5, 5); tick(); chk_sel("alu_s3", 3, 3);
    issue(1, 0, 0, 0, 5, 5); tick(); chk_sel("alu_gone", 0, 0);

    // Youngest producer wins
    issue(1, 1, 0, 7, 0, 0); tick();
    issue(1, 1, 0, 7, 0, 0); tick();
    issue(1, 0, 0, 0, 7, 7); tick(); chk_sel("youngest", 2, 2);

    // Load-use: one bubble then forward from stage 3
    issue(1, 1, 1, 9, 0, 0); tick();
    issue(1, 0, 0, 0, 9, 1);
    #1 check("lu_haz", 32'(hazard), 1);
    tick(); chk_sel("lu_bubble", 0, 0);
    #1 check("lu_retry_haz", 32'(hazard), 0);
    tick(); chk_sel("lu_retry", 3, 0);

    // x0 is never tracked
    issue(1, 1, 0, 0, 0, 0); tick();
    issue(1, 0, 0, 0, 0, 0); tick(); chk_sel("x0", 0, 0);

    // Flush masks the load-use stall and inserts a bubble
    issue(1, 1, 1, 9, 0, 0); tick();
    issue(1, 1, 0, 10, 9, 9);
    flush = 1'b1;
    #1 check("flush_haz", 32'(hazard), 0);
    tick(); chk_sel("flush_bubble", 0, 0);
    flush = 1'b0;
    issue(1, 0, 0, 0, 9, 10); tick(); chk_sel("flush_after", 3, 0);

    // External stall freezes entries and selects
    issue(1, 1, 0, 6, 0, 0); tick();
    issue(1, 1, 0, 8, 6, 0); tick(); chk_sel("pre_stall", 2, 0);
    stall = 1'b1;
    issue(1, 0, 0, 0, 6, 6);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_sel("stall_hold", 2, 0);
    end
    stall = 1'b0;
    tick(); chk_sel("post_stall", 3, 3);

    // Hazard still evaluated under stall; stall dominates
    issue(1, 1, 1, 11, 8, 0); tick(); chk_sel("ld_fwd", 3, 0);
    stall = 1'b1;
    issue(1, 0, 0, 0, 11, 0);
    #1 check("stall_haz", 32'(hazard), 1);
    tick(); chk_sel("stall_haz_hold", 3, 0);
    stall = 1'b0;
    #1 check("unstall_haz", 32'(hazard), 1);
    tick(); chk_sel("unstall_bubble", 0, 0);
    tick(); chk_sel("unstall_retry", 3, 0);

    // Reset mid-flight clears the board immediately
    issue(1, 1, 0, 6, 0, 0); tick();
    issue(1, 0, 0, 0, 6, 6); tick(); chk_sel("pre_rst", 2, 2);
    rst_n = 1'b0;
    #1 chk_sel("rst_async", 0, 0);
`ifdef FWD_STATS_EN
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_fwd_cnt", fwd_cnt, 0);
`endif
    #1 rst_n = 1'b1;
    issue(1, 0, 0, 0, 6, 6);
    tick(); chk_sel("post_rst", 0, 0);

    issue(0, 0, 0, 0, 0, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding-and-hazard scoreboard for the in-order integer pipeline. It tracks the destination register of every in-flight instruction across DEPTH post-issue stages. At issue time it resolves, for each of NSRC source operands, which stage will hold the freshest value when the consumer reaches EX. It also raises a load-use stall when the value cannot be forwarded in time. It sits beside the ID/EX boundary and drives the EX-stage operand muxes.

## Interface
- REG_AW, 5: register index width.
- NSRC, 2: source operands per instruction.
- DEPTH, 3: tracked post-issue stages (stage 1 = EX … stage DEPTH = last stage before write-back completes).
- LOAD_READY, 3: earliest stage index (in the consumer's EX cycle) from which load data may be forwarded; 2..DEPTH.
- SELW, derived = $clog2(DEPTH+1): select width.

Clock and reset are fixed: one clock; reset is asynchronous and active-low.

- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- issue_valid_i  in  1  instruction in ID requests issue.
- issue_wen_i  in  1  instruction writes a register.
- issue_load_i  in  1  instruction is a load.
- issue_rd_i  in  REG_AW  destination register.
- issue_rs_i  in  NSRC*REG_AW  source registers; source n at bits [n*REG_AW +: REG_AW].
- stall_i  in  1  external pipeline freeze.
- flush_i  in  1  kill the instruction in ID.
- fwd_sel_o  out  NSRC*SELW  registered per-source select for the EX-cycle instruction: 0 = register file, k = stage k.
- hazard_stall_o  out  1  combinational load-use stall request.

## Operation
- Entry per stage: valid, rd, is_load.
  - Entry is written only when issue_valid_i & issue_wen_i & (issue_rd_i != 0).
  - Otherwise the stage holds a bubble (valid = 0).
- Match rules:
  - Source n matches entry j (1..DEPTH-1) when the entry is valid, rd == rs[n], and rs[n] != 0.
  - Entry DEPTH is writing back this cycle; it is never a forward source and selects 0, because the register file is write-first.
- Priority: youngest match wins, i.e. the lowest j.
  - Selected value = j+1, the producer's stage in the consumer's EX cycle.
  - No match gives 0.
- Load-use: hazard_stall_o = issue_valid_i & !flush_i & any source whose winning match is a load with j+1 < LOAD_READY.
- Advance, when !stall_i:
  - Entries shift: stage j+1 ← stage j.
  - Stage 1 ← new entry, or a bubble if hazard_stall_o, flush_i or !issue_valid_i.
  - fwd_sel_o ← computed selects, or all zero for a bubble.
- stall_i = 1: all entries and fwd_sel_o hold. hazard_stall_o is still evaluated.
- Simultaneous events:
  - stall_i dominates hazard_stall_o and flush_i.
  - flush_i masks hazard_stall_o.

## Timing
- Reset: every entry valid = 0, fwd_sel_o = 0, hazard_stall_o = 0 (no issue), stats counters = 0.
- The issue cycle computes the selects; fwd_sel_o is valid in the next cycle, the consumer's EX cycle.
- An instruction leaves the scoreboard DEPTH un-stalled cycles after issue.
- Load-use with default parameters: one bubble. On re-evaluation the producer is at stage 2 and becomes 3 in EX, so the select is 3.
- Reset asserted mid-operation clears all entries immediately; the first cycle after release sees an empty board.

## Configuration
- FWD_STATS_EN defined: adds stall_cnt_o (32) and fwd_cnt_o (32), both saturating at all-ones.
  - stall_cnt_o increments on every cycle with hazard_stall_o & !stall_i.
  - fwd_cnt_o increments by the number of nonzero selects loaded into fwd_sel_o.
  - Both clear on reset.
- FWD_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- fwd_pkg holds:
  - the fwd_entry_t struct (valid, rd, is_load), parameterised by REG_AW through a localparam default;
  - a function returning SELW;
  - the localparam SEL_RF = 0.
- Sub-module fwd_match, instantiated NSRC times. Given one rs and the entry vector, it returns the winning select and a load-not-ready flag. It is purely combinational with a priority encode over j.

## Test plan
- Reset and empty board: reset, then issue rs = {3,4} → next cycle fwd_sel_o = {0,0}; hazard_stall_o stays 0.
- Back-to-back ALU chain: issue rd = 5, then issue rs = {5,0} → fwd_sel_o source 0 = 2, source 1 = 0. Issue rs = {5,5} one bubble later → both = 3. Two bubbles later → both = 0.
- Youngest priority: issue rd = 7, then rd = 7, then rs = {7,7} → both = 2, not 3.
- Load-use: issue load rd = 9, then rs = {9,1} → hazard_stall_o = 1 for one cycle and fwd_sel_o = 0 (bubble). The retried issue gives source 0 = 3.
- x0 and flush: issue rd = 0, then rs = {0,0} → {0,0}. Issue load rd = 9, then rs = {9,9} with flush_i = 1 → hazard_stall_o = 0 and a bubble is inserted.
- External stall and reset mid-flight: issue rd = 6, hold stall_i for 3 cycles → fwd_sel_o and entries frozen. Then issue rs = {6,6} → 2. Assert rst_n_i = 0 with entries live → fwd_sel_o = 0 and the next rs = {6,6} gives 0. With FWD_STATS_EN defined, the counters read 0 after reset.
